// File: rtl/irq_src_conditioner_if.sv
// Interrupt-line bundle between peripherals/pins and irq_src_conditioner.
// master = the side driving raw lines, mask and clears; slave = the conditioner.
interface irq_src_conditioner_if #(
    parameter int NumSrc = 32
);
    logic [NumSrc-1:0] intr_raw_i;
    logic [NumSrc-1:0] intr_mask_i;
    logic [NumSrc-1:0] status_clr_i;
    logic [NumSrc-1:0] intr_src_o;
    logic [NumSrc-1:0] status_o;

    modport master (
        output intr_raw_i,
        output intr_mask_i,
        output status_clr_i,
        input  intr_src_o,
        input  status_o
    );

    modport slave (
        input  intr_raw_i,
        input  intr_mask_i,
        input  status_clr_i,
        output intr_src_o,
        output status_o
    );
endinterface

// File: rtl/irq_src_conditioner.sv
// Per-source synchronise, polarity-correct and debounce of raw interrupt lines, then level passthrough or
// rising-edge-to-stretched-pulse. Define IRQ_SRC_COND_STATUS_EN to build the sticky status flags.
module irq_src_conditioner #(
    parameter int               NumSrc         = 32,
    parameter int               SyncStages     = 2,
    parameter int               DebounceCycles = 3,
    parameter int               StretchCycles  = 4,
    parameter logic [NumSrc-1:0] InvertMask    = '0,
    parameter logic [NumSrc-1:0] EdgeMask      = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    irq_src_conditioner_if.slave  bus
);

    localparam int DbW = $clog2(DebounceCycles + 1);
    localparam int StW = $clog2(StretchCycles + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);
    localparam logic [StW-1:0] StLoad = StW'(StretchCycles);

    logic [SyncStages-1:0][NumSrc-1:0] sync_q, sync_d;
    logic [NumSrc-1:0]                 rawS;
    logic [NumSrc-1:0]                 filt_q, filt_d;
    logic [NumSrc-1:0]                 prev_q;
    logic [NumSrc-1:0]                 rise;
    logic [NumSrc-1:0][DbW-1:0]        cntDb_q, cntDb_d;
    logic [NumSrc-1:0][StW-1:0]        cntSt_q, cntSt_d;
    logic [NumSrc-1:0]                 stretchOn;
    logic [NumSrc-1:0]                 condOut;

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], bus.intr_raw_i};
    end

    assign rawS = sync_q[SyncStages-1] ^ InvertMask;

    // Any cycle that agrees with the accepted value restarts qualification.
    always_comb begin
        filt_d  = filt_q;
        cntDb_d = cntDb_q;
        for (int i = 0; i < NumSrc; i++) begin
            if (rawS[i] == filt_q[i]) begin
                cntDb_d[i] = '0;
            end else if (cntDb_q[i] == DbLast) begin
                filt_d[i]  = rawS[i];
                cntDb_d[i] = '0;
            end else begin
                cntDb_d[i] = cntDb_q[i] + 1'b1;
            end
        end
    end

    assign rise = filt_q & ~prev_q;

    // A rise reloads the counter even mid-pulse, so back-to-back rises merge.
    always_comb begin
        cntSt_d   = cntSt_q;
        stretchOn = '0;
        for (int i = 0; i < NumSrc; i++) begin
            stretchOn[i] = (cntSt_q[i] != '0);
            if (rise[i]) begin
                cntSt_d[i] = StLoad;
            end else if (cntSt_q[i] != '0) begin
                cntSt_d[i] = cntSt_q[i] - 1'b1;
            end
        end
    end

    assign condOut        = (EdgeMask & stretchOn) | (~EdgeMask & filt_q);
    assign bus.intr_src_o = condOut & bus.intr_mask_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            cntDb_q <= '0;
            cntSt_q <= '0;
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            cntDb_q <= cntDb_d;
            cntSt_q <= cntSt_d;
        end
    end

`ifdef IRQ_SRC_COND_STATUS_EN
    logic [NumSrc-1:0] status_q, status_d;

    // Set wins over a coincident clear; the mask does not gate the flag.
    always_comb begin
        status_d = (status_q & ~bus.status_clr_i) | (filt_d & ~filt_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign bus.status_o = status_q;
`else
    logic [NumSrc-1:0] unusedStatusClr;

    assign unusedStatusClr = bus.status_clr_i;
    assign bus.status_o    = '0;
`endif

endmodule

// File: tb/tb_irq_src_conditioner.sv
// Randomised scoreboard bench for irq_src_conditioner against a window-based behavioural model.
module tb_irq_src_conditioner;

    localparam int NumSrc         = 32;
    localparam int SyncStages     = 2;
    localparam int DebounceCycles = 3;
    localparam int StretchCycles  = 4;
    localparam logic [NumSrc-1:0] InvertMask = 32'h00FF_0008;
    localparam logic [NumSrc-1:0] EdgeMask   = 32'h0F0F_00F4;
    localparam int NumCycles      = 4000;

    typedef struct {
        logic [NumSrc-1:0] src;
        logic [NumSrc-1:0] stat;
    } expT;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    expT  expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    logic [SyncStages-1:0]     rawHist [NumSrc];
    logic [DebounceCycles-1:0] win     [NumSrc];
    logic [NumSrc-1:0]         filtM;
    logic [NumSrc-1:0]         statM;
    int                        sinceRise [NumSrc];

    logic [NumSrc-1:0] rawVal;
    int                holdLeft [NumSrc];
    logic [NumSrc-1:0] maskVal;

    always #5 clk_i = ~clk_i;

    irq_src_conditioner_if #(.NumSrc(NumSrc)) bus ();

    irq_src_conditioner #(
        .NumSrc         (NumSrc),
        .SyncStages     (SyncStages),
        .DebounceCycles (DebounceCycles),
        .StretchCycles  (StretchCycles),
        .InvertMask     (InvertMask),
        .EdgeMask       (EdgeMask)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // A source accepts a new value once its last DebounceCycles synchronised samples all show it;
    // an edge source is high during the StretchCycles cycles after its most recent accepted rise.
    task automatic modelStep(input logic rst, input logic [NumSrc-1:0] raw, input logic [NumSrc-1:0] mask,
                             input logic [NumSrc-1:0] clr, output expT e);
        logic rs;
        logic rose;
        logic [NumSrc-1:0] cond;
        cond = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (rst) begin
                rawHist[i]   = '0;
                win[i]       = '0;
                filtM[i]     = 1'b0;
                statM[i]     = 1'b0;
                sinceRise[i] = StretchCycles + 1;
            end else begin
                rs         = rawHist[i][SyncStages-1] ^ InvertMask[i];
                rawHist[i] = {rawHist[i][SyncStages-2:0], raw[i]};
                win[i]     = {win[i][DebounceCycles-2:0], rs};
                rose       = 1'b0;
                if (!filtM[i] && win[i] == {DebounceCycles{1'b1}}) begin
                    filtM[i] = 1'b1;
                    rose     = 1'b1;
                end else if (filtM[i] && win[i] == {DebounceCycles{1'b0}}) begin
                    filtM[i] = 1'b0;
                end
                if (rose) sinceRise[i] = 0;
                else if (sinceRise[i] <= StretchCycles) sinceRise[i]++;
                statM[i] = (statM[i] & ~clr[i]) | rose;
            end
            if (EdgeMask[i]) cond[i] = (sinceRise[i] >= 1) && (sinceRise[i] <= StretchCycles);
            else             cond[i] = filtM[i];
        end
        e.src = cond & mask;
`ifdef IRQ_SRC_COND_STATUS_EN
        e.stat = statM;
`else
        e.stat = '0;
`endif
    endtask

    task automatic applyStimulus(input logic rst, input logic [NumSrc-1:0] raw, input logic [NumSrc-1:0] mask,
                                 input logic [NumSrc-1:0] clr);
        expT e;
        @(negedge clk_i);
        rst_i            = rst;
        bus.intr_raw_i   = raw;
        bus.intr_mask_i  = mask;
        bus.status_clr_i = clr;
        modelStep(rst, raw, mask, clr, e);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expT e);
        vectors++;
        if (bus.intr_src_o !== e.src) begin
            miscompares++;
            $display("[TB] FAIL intr_src cycle %0d: got %h expected %h", cycle, bus.intr_src_o, e.src);
        end
        vectors++;
        if (bus.status_o !== e.stat) begin
            miscompares++;
            $display("[TB] FAIL status cycle %0d: got %h expected %h", cycle, bus.status_o, e.stat);
        end
    endtask

    always @(posedge clk_i) begin
        expT e;
        #1;
        cycle++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        int resetLeft;
        logic doRst;
        bus.intr_raw_i   = '0;
        bus.intr_mask_i  = '1;
        bus.status_clr_i = '0;
        rawVal    = '0;
        maskVal   = '1;
        resetLeft = 0;
        for (int i = 0; i < NumSrc; i++) holdLeft[i] = $urandom_range(1, 10);

        repeat (3) applyStimulus(1'b1, '0, '1, '0);

        for (int n = 0; n < NumCycles; n++) begin
            for (int i = 0; i < NumSrc; i++) begin
                if (holdLeft[i] == 0) begin
                    rawVal[i]   = ~rawVal[i];
                    holdLeft[i] = $urandom_range(1, 10);
                end
                holdLeft[i]--;
            end
            if (resetLeft == 0 && $urandom_range(0, 249) == 0) resetLeft = $urandom_range(1, 3);
            doRst = (resetLeft > 0);
            if (resetLeft > 0) resetLeft--;
            if ($urandom_range(0, 3) == 0) maskVal = $urandom | $urandom;
            applyStimulus(doRst, rawVal, maskVal, $urandom & $urandom & $urandom);
        end

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk_i);
        #2;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
